// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus between decode/write-back and the multi-port register file
// Signals: clr (full clear request), ready (file initialised),
//          we0/waddr0/wdata0 and we1/waddr1/wdata1 (write ports, port 1 wins),
//          mark_en/mark_addr (set pending), re/raddr (read requests),
//          rdata/rpend (combinational read data and hazard flags).
// master drives requests; slave is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();
    logic                     clr;
    logic                     ready;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     mark_en;
    logic [ADDR_W-1:0]        mark_addr;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rpend;

    modport master (
        output clr, we0, waddr0, wdata0, we1, waddr1, wdata1, mark_en, mark_addr, re, raddr,
        input  ready, rdata, rpend
    );

    modport slave (
        input  clr, we0, waddr0, wdata0, we1, waddr1, wdata1, mark_en, mark_addr, re, raddr,
        output ready, rdata, rpend
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, clear sequencer and pending scoreboard
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
//        bus (regfile_mp_if.slave: write ports, mark, read ports, ready).
// Reg 0 reads as zero and is never written. After reset or clr the file
// walks every index writing zero, then raises ready.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic              r_ready, w_ready_nxt;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic              w_wr_ok, w_we0, w_we1, w_mark;
    logic [ADDR_W-1:0] w_raddr [NUM_RD];
    logic [DATA_W-1:0] w_rdata [NUM_RD];
    logic              w_rpend [NUM_RD];
    logic              w_hit0  [NUM_RD];
    logic              w_hit1  [NUM_RD];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready_nxt = r_ready;
        if (r_state == CLEAR) begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == LAST) begin
                w_state_nxt = READY;
                w_ready_nxt = 1'b1;
            end
        end else if (bus.clr) begin
            w_state_nxt = CLEAR;
            w_idx_nxt   = '0;
            w_ready_nxt = 1'b0;
        end
    end

    // A clr edge discards the writes and mark presented with it.
    assign w_wr_ok = !rst && r_state == READY && !bus.clr;
    assign w_we0   = w_wr_ok && bus.we0 && bus.waddr0 != '0;
    assign w_we1   = w_wr_ok && bus.we1 && bus.waddr1 != '0;
    assign w_mark  = w_wr_ok && bus.mark_en && bus.mark_addr != '0;

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_regs[r_idx] <= '0;
        end else begin
            if (w_we0) r_regs[bus.waddr0] <= bus.wdata0;
            if (w_we1) r_regs[bus.waddr1] <= bus.wdata1;
        end
    end

    // Mark is applied after the write clears so a same-address mark wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else if (r_state == CLEAR) begin
            r_pend[r_idx] <= 1'b0;
        end else begin
            if (w_we0)  r_pend[bus.waddr0]    <= 1'b0;
            if (w_we1)  r_pend[bus.waddr1]    <= 1'b0;
            if (w_mark) r_pend[bus.mark_addr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign w_raddr[g] = bus.raddr[g*ADDR_W +: ADDR_W];
        assign w_hit1[g]  = bus.we1 && bus.waddr1 == w_raddr[g];
        assign w_hit0[g]  = bus.we0 && bus.waddr0 == w_raddr[g];
        assign w_rdata[g] = (rst || !r_ready || !bus.re[g] || w_raddr[g] == '0) ? '0 :
                            w_hit1[g] ? bus.wdata1 :
                            w_hit0[g] ? bus.wdata0 : r_regs[w_raddr[g]];
        // A bypassed value is already available, so it never reports pending.
        assign w_rpend[g] = r_ready && bus.re[g] && w_raddr[g] != '0 &&
                            r_pend[w_raddr[g]] && !(w_hit0[g] || w_hit1[g]);
    end

    always_comb begin
        bus.rdata = '0;
        bus.rpend = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rdata[i*DATA_W +: DATA_W] = w_rdata[i];
            bus.rpend[i]                  = w_rpend[i];
        end
    end

    assign bus.ready = r_ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, corner sequences and random traffic against a reference model
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic clk, rst;
    int   n_chk = 0;
    int   n_pass = 0;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: file contents, pending flags, and remaining clear edges.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_ready;
    bit            m_valid = 0;
    int            m_left;

    typedef struct {
        logic [1:0]    re;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          mk;
        logic [AW-1:0] ma;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] e0, e1;
        logic [1:0]    ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [31:0] re, we0, wa0, wd0, we1, wa1, wd1,
                               mk, ma, ra0, ra1, e0, e1, ep);
        vec_t r;
        r.re = 2'(re);   r.we0 = we0[0]; r.wa0 = AW'(wa0); r.wd0 = wd0;
        r.we1 = we1[0];  r.wa1 = AW'(wa1); r.wd1 = wd1;
        r.mk = mk[0];    r.ma = AW'(ma);
        r.ra0 = AW'(ra0); r.ra1 = AW'(ra1);
        r.e0 = e0; r.e1 = e1; r.ep = 2'(ep);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic idle();
        bus.clr = 0; bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.mark_en = 0; bus.mark_addr = '0; bus.re = '1; bus.raddr = '0;
    endtask

    task automatic exp_read(input int p, output logic [DW-1:0] d, output logic pd);
        logic [AW-1:0] ra;
        logic          hit;
        ra  = bus.raddr[p*AW +: AW];
        hit = (bus.we1 && bus.waddr1 == ra) || (bus.we0 && bus.waddr0 == ra);
        if (rst || !m_ready || !bus.re[p] || ra == 0) d = '0;
        else if (bus.we1 && bus.waddr1 == ra) d = bus.wdata1;
        else if (bus.we0 && bus.waddr0 == ra) d = bus.wdata0;
        else d = m_regs[ra];
        pd = m_ready && bus.re[p] && ra != 0 && m_pend[ra] && !hit;
    endtask

    task automatic check_now();
        logic [DW-1:0] d;
        logic          pd;
        if (!m_valid) return;
        chk("ready", 32'(bus.ready), 32'(m_ready));
        for (int p = 0; p < NR; p++) begin
            exp_read(p, d, pd);
            chk($sformatf("rdata%0d", p), bus.rdata[p*DW +: DW], d);
            chk($sformatf("rpend%0d", p), 32'(bus.rpend[p]), 32'(pd));
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_valid = 1;
            m_ready = 0;
            m_left  = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 0;
        end else if (!m_valid) begin
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
            end
        end else if (bus.clr) begin
            m_ready = 0;
            m_left  = DEPTH;
        end else begin
            if (bus.we0 && bus.waddr0 != 0) begin m_regs[bus.waddr0] = bus.wdata0; m_pend[bus.waddr0] = 0; end
            if (bus.we1 && bus.waddr1 != 0) begin m_regs[bus.waddr1] = bus.wdata1; m_pend[bus.waddr1] = 0; end
            if (bus.mark_en && bus.mark_addr != 0) m_pend[bus.mark_addr] = 1;
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_now();
        edge_();
    endtask

    task automatic wait_ready(input string nm, input bit noisy);
        int n = 0;
        do begin
            if (noisy) begin
                bus.we0 = 1; bus.waddr0 = AW'($urandom_range(1, DEPTH-1)); bus.wdata0 = $urandom;
                bus.we1 = 1; bus.waddr1 = AW'($urandom_range(1, DEPTH-1)); bus.wdata1 = $urandom;
                bus.mark_en = 1; bus.mark_addr = AW'($urandom_range(1, DEPTH-1));
            end
            tick();
            n++;
        end while (bus.ready !== 1'b1 && n < 40);
        chk(nm, 32'(n), 32'd32);
        idle();
    endtask

    task automatic sweep_zero(input string nm);
        for (int a = 0; a < DEPTH; a++) begin
            bus.raddr = {AW'(a), AW'(DEPTH-1-a)};
            @(negedge clk);
            chk(nm, bus.rdata, '0);
            chk({nm, "_pend"}, 32'(bus.rpend), 32'd0);
            check_now();
            edge_();
        end
    endtask

    task automatic rand_inputs();
        logic [AW-1:0] pick;
        rst = ($urandom_range(0, 299) == 0);
        bus.clr = ($urandom_range(0, 99) == 0);
        bus.we0 = 1'($urandom); bus.waddr0 = AW'($urandom); bus.wdata0 = $urandom;
        bus.we1 = 1'($urandom); bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'($urandom);
        bus.wdata1 = $urandom;
        bus.mark_en = ($urandom_range(0, 2) == 0);
        bus.mark_addr = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'($urandom);
        bus.re = 2'($urandom);
        for (int p = 0; p < NR; p++) begin
            case ($urandom_range(0, 3))
                0: pick = bus.waddr0;
                1: pick = bus.waddr1;
                2: pick = bus.mark_addr;
                default: pick = AW'($urandom);
            endcase
            bus.raddr[p*AW +: AW] = pick;
        end
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        wait_ready("init_latency", 0);
        sweep_zero("init_zero");

        //     re we0 wa0 wd0          we1 wa1 wd1   mk ma ra0 ra1 e0           e1           ep
        tbl.push_back(v(3, 1, 5, 32'hDEADBEEF, 0, 0, 0,    0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 5, 0, 32'hDEADBEEF, 0,            0));
        tbl.push_back(v(3, 1, 0, 32'h1234,     0, 0, 0,    0, 0, 0, 5, 0,            32'hDEADBEEF, 0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 0, 0, 0,            0,            0));
        tbl.push_back(v(3, 1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 7, 32'h22,     32'h22,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 7, 8, 32'h22,       0,            0));
        tbl.push_back(v(3, 1, 7, 32'h33,       1, 8, 32'h44, 0, 0, 7, 8, 32'h33,     32'h44,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 7, 8, 32'h33,       32'h44,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    1, 9, 9, 9, 0,            0,            0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 9, 8, 0,            32'h44,       1));
        tbl.push_back(v(3, 1, 9, 32'h55,       0, 0, 0,    0, 0, 9, 9, 32'h55,       32'h55,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 9, 9, 32'h55,       32'h55,       0));
        tbl.push_back(v(3, 0, 0, 0,            1, 9, 32'h66, 1, 9, 9, 9, 32'h66,     32'h66,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 9, 9, 32'h66,       32'h66,       3));
        tbl.push_back(v(3, 0, 0, 0,            1, 9, 32'h77, 0, 0, 9, 9, 32'h77,     32'h77,       0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,    0, 0, 9, 9, 32'h77,       0,            0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    1, 12, 0, 0, 0,           0,            0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,    1, 0, 12, 12, 0,          0,            1));
        tbl.push_back(v(3, 1, 12, 32'h99,      0, 0, 0,    0, 0, 12, 12, 32'h99,     32'h99,       0));
        tbl.push_back(v(3, 0, 0, 0,            0, 0, 0,    0, 0, 12, 0, 32'h99,      0,            0));

        foreach (tbl[k]) begin
            bus.re = tbl[k].re;
            bus.we0 = tbl[k].we0; bus.waddr0 = tbl[k].wa0; bus.wdata0 = tbl[k].wd0;
            bus.we1 = tbl[k].we1; bus.waddr1 = tbl[k].wa1; bus.wdata1 = tbl[k].wd1;
            bus.mark_en = tbl[k].mk; bus.mark_addr = tbl[k].ma;
            bus.raddr = {tbl[k].ra1, tbl[k].ra0};
            @(negedge clk);
            chk($sformatf("vec%0d_rd0", k), bus.rdata[DW-1:0], tbl[k].e0);
            chk($sformatf("vec%0d_rd1", k), bus.rdata[2*DW-1:DW], tbl[k].e1);
            chk($sformatf("vec%0d_rp", k), 32'(bus.rpend), 32'(tbl[k].ep));
            check_now();
            edge_();
        end
        idle();

        for (int i = 1; i < DEPTH; i++) begin
            bus.we0 = 1; bus.waddr0 = AW'(i); bus.wdata0 = 32'h1000_0000 | i;
            tick();
        end
        idle();
        bus.mark_en = 1; bus.mark_addr = 3;
        tick();
        idle();
        bus.raddr = {AW'(31), AW'(3)};
        @(negedge clk);
        chk("preclr_rd1", bus.rdata[2*DW-1:DW], 32'h1000_001F);
        chk("preclr_rp0", 32'(bus.rpend[0]), 32'd1);
        edge_();
        bus.clr = 1; bus.we0 = 1; bus.waddr0 = 4; bus.wdata0 = 32'hBAD;
        tick();
        idle();
        wait_ready("clr_latency", 1);
        sweep_zero("clr_zero");

        bus.clr = 1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        rst = 1; bus.clr = 1;
        tick();
        rst = 0; bus.clr = 0;
        wait_ready("rst_midclear_latency", 0);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the CPU core, replacing the fixed 2-read/1-write file between decode (read) and write-back (write). Adds a configurable number of read ports, two prioritised write ports with same-cycle bypass, a self-clearing initialisation sequencer, and a per-register pending scoreboard that lets decode detect read-after-write hazards on in-flight results.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  request full-file clear; honoured only in READY
- ready  out  1  registered; 1 = file initialised, writes/reads live
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- mark_en  in  1  set pending bit of mark_addr
- mark_addr  in  ADDR_W  register being allocated to an in-flight producer
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  combinational read data, port i at [i*DATA_W +: DATA_W]
- rpend  out  NUM_RD  combinational; 1 = port i's register still awaits its producer

## Operation
- States: CLEAR, READY. Registered clear index idx (ADDR_W bits).
- rst=1 at an edge: state←CLEAR, idx←0, ready←0, all pending bits←0. Register contents not required to change on that edge.
- CLEAR: each edge writes regs[idx]←0, pending[idx]←0, idx←idx+1; on the edge where idx==DEPTH-1, state←READY, ready←1. we0/we1/mark_en ignored.
- READY: clr=1 at an edge → state←CLEAR, idx←0, ready←0; writes and mark on that same edge are discarded.
- Writes (READY only): reg 0 is never written and always reads 0. we0 and we1 to the same address → port 1 data stored. Different addresses → both stored.
- Pending: a write on either port clears pending[waddr]; mark_en sets pending[mark_addr]. Mark and write to same address on one edge → pending ends 1 (mark wins). mark_addr==0 ignored.
- Read port i (combinational, priority order): rst=1 or ready=0 → 0; re[i]=0 → 0; raddr_i==0 → 0; we1 && waddr1==raddr_i → wdata1; we0 && waddr0==raddr_i → wdata0; else regs[raddr_i].
- rpend[i] = ready & re[i] & (raddr_i≠0) & pending[raddr_i] & ~(bypass hit on port i); bypassed value is treated as available.
- All read ports independent; any number may address the same register.

## Timing
- Reset values: ready=0, rdata=0, rpend=0, state=CLEAR, idx=0.
- Initialisation latency: ready rises DEPTH edges after the first edge with rst=0 (32 edges at defaults); same for clr.
- Write latency: 1 edge to storage; 0 cycles to rdata via bypass.
- Mark latency: pending visible on rpend the cycle after the mark edge.
- rst asserted mid-CLEAR restarts idx at 0; rst has priority over clr.
- No combinational path from rdata/rpend back to any input.

## Test plan
- Reset then idle: rst=1 two cycles, release → ready=0 for 32 edges, ready=1 after 32nd; all ports read 0 from every address.
- Write/readback: we0 waddr0=5 wdata0=0xDEADBEEF, next cycle raddr[0]=5 → 0xDEADBEEF; same cycle raddr[1]=5 → 0xDEADBEEF via bypass; write to reg 0 with 0x1234 → reads 0.
- Write collision: we0/we1 both to 7 with 0x11/0x22 → same-cycle bypass 0x22, stored 0x22; to 7 and 8 → both stored.
- Scoreboard: mark 9 → next cycle rpend=1 on a port reading 9; write 9 with 0x55 → rpend=0 that cycle (bypass) and after; simultaneous mark 9 + write 9 → pending remains 1.
- Clear mid-run: load regs 1..31 nonzero, pulse clr → ready=0 for 32 edges, writes during CLEAR discarded, all regs 0 and no pending afterward.
- Reset mid-CLEAR: assert rst at idx=10 → idx restarts, ready rises exactly 32 edges after rst release.
